// File: rtl/pwm_timebase.sv
// PWM time base: prescaler, edge/center-aligned period counter with shadowed
// period, rollover strobe for the duty shadow register, and registered compare output.
module pwm_timebase #(
    parameter int CNT_W = 16,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             center_mode,
    input  logic             polarity,
    input  logic [PRE_W-1:0] prescale,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty_cycle_in,
    output logic [CNT_W-1:0] count,
    output logic             rollover,
    output logic             pwm_out,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] period_sh;
    logic             mode_sh;
    logic             tick;
    logic             wrap;

    assign running = (state != IDLE);

    // Prescaler tick and the wrap point where a period ends
    always_comb begin
        tick = running && (pre_cnt == prescale);
        wrap = 1'b0;
        case (state)
            RUN_UP:   wrap = mode_sh ? (period_sh == {CNT_W{1'b0}}) : (count == period_sh);
            RUN_DOWN: wrap = mode_sh && (count == {CNT_W{1'b0}});
            default:  wrap = 1'b0;
        endcase
    end

    // Rollover covers both the start strobe and the end-of-period wrap; a stop cycle never strobes
    always_comb begin
        if (rst || !enable) begin
            rollover = 1'b0;
        end else if (state == IDLE) begin
            rollover = 1'b1;
        end else begin
            rollover = tick && wrap;
        end
    end

    // Timer state, counter, shadows and registered PWM compare
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= {CNT_W{1'b0}};
            pre_cnt   <= {PRE_W{1'b0}};
            period_sh <= {CNT_W{1'b0}};
            mode_sh   <= 1'b0;
            pwm_out   <= 1'b0;
        end else begin
            if (running) begin
                pwm_out <= (count < duty_cycle_in) ^ polarity;
            end else begin
                pwm_out <= polarity;
            end

            if (state == IDLE) begin
                count   <= {CNT_W{1'b0}};
                pre_cnt <= {PRE_W{1'b0}};
                if (enable) begin
                    state     <= RUN_UP;
                    period_sh <= period;
                    mode_sh   <= center_mode;
                end else begin
                    state <= IDLE;
                end
            end else if (!enable) begin
                state   <= IDLE;
                count   <= {CNT_W{1'b0}};
                pre_cnt <= {PRE_W{1'b0}};
            end else begin
                pre_cnt <= tick ? {PRE_W{1'b0}} : pre_cnt + PRE_W'(1);
                if (tick) begin
                    case (state)
                        RUN_UP: begin
                            if (count < period_sh) begin
                                count <= count + CNT_W'(1);
                            end else if (!mode_sh || (period_sh == {CNT_W{1'b0}})) begin
                                count     <= {CNT_W{1'b0}};
                                period_sh <= period;
                            end else begin
                                state <= RUN_DOWN;
                                count <= period_sh - CNT_W'(1);
                            end
                        end
                        RUN_DOWN: begin
                            if (count != {CNT_W{1'b0}}) begin
                                count <= count - CNT_W'(1);
                            end else begin
                                // a zero-length reloaded period parks at 0 so count never exceeds period_sh
                                state     <= RUN_UP;
                                count     <= (period == {CNT_W{1'b0}}) ? {CNT_W{1'b0}} : CNT_W'(1);
                                period_sh <= period;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            count <= {CNT_W{1'b0}};
                        end
                    endcase
                end else begin
                    count <= count;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_timebase.sv
// Scoreboard bench for pwm_timebase: a phase-based reference model pushes the
// expected outputs each cycle; a negedge monitor pops and compares.
module tb_pwm_timebase;

    logic        clk = 1'b0;
    logic        rst, enable, center_mode, polarity;
    logic [7:0]  prescale;
    logic [15:0] period, duty_cycle_in;
    logic [15:0] count;
    logic        rollover, pwm_out, running;

    always #5 clk = ~clk;

    pwm_timebase #(.CNT_W(16), .PRE_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .center_mode(center_mode),
        .polarity(polarity), .prescale(prescale), .period(period),
        .duty_cycle_in(duty_cycle_in), .count(count), .rollover(rollover),
        .pwm_out(pwm_out), .running(running)
    );

    typedef struct packed {
        logic [15:0] cnt;
        logic        roll;
        logic        pwm;
        logic        run;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: position within the period is a phase index, count derived from it
    bit m_run, m_center, m_pwm, exp_roll;
    int m_P, m_ph, m_k;
    int duty_next;

    function automatic int model_count();
        if (!m_run) return 0;
        if (!m_center) return m_ph;
        return (m_ph <= m_P) ? m_ph : 2 * m_P - m_ph;
    endfunction

    function automatic bit model_wrap();
        if (m_center) return (m_P == 0) || (m_ph == 2 * m_P);
        return m_ph == m_P;
    endfunction

    function automatic void push_expected();
        exp_t e;
        exp_roll = !rst && enable && (!m_run || ((m_k == int'(prescale)) && model_wrap()));
        e.cnt  = 16'(model_count());
        e.roll = exp_roll;
        e.pwm  = m_pwm;
        e.run  = m_run;
        q.push_back(e);
    endfunction

    function automatic void step();
        if (rst) begin
            m_run = 1'b0; m_center = 1'b0; m_pwm = 1'b0;
            m_P = 0; m_ph = 0; m_k = 0;
        end else begin
            m_pwm = m_run ? ((model_count() < int'(duty_cycle_in)) ^ polarity) : polarity;
            if (!m_run) begin
                if (enable) begin
                    m_run = 1'b1; m_ph = 0; m_k = 0;
                    m_P = int'(period); m_center = center_mode;
                end
            end else if (!enable) begin
                m_run = 1'b0; m_ph = 0; m_k = 0;
            end else if (m_k == int'(prescale)) begin
                m_k = 0;
                if (model_wrap()) begin
                    m_ph = (m_center && m_P != 0 && period != 16'd0) ? 1 : 0;
                    m_P  = int'(period);
                end else begin
                    m_ph = m_ph + 1;
                end
            end else begin
                m_k = m_k + 1;
            end
        end
        if (exp_roll) duty_cycle_in = 16'(duty_next);
    endfunction

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            push_expected();
            @(posedge clk);
            #1;
            step();
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("count", int'(count), int'(e.cnt));
            chk("rollover", int'(rollover), int'(e.roll));
            chk("pwm_out", int'(pwm_out), int'(e.pwm));
            chk("running", int'(running), int'(e.run));
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b1; center_mode = 1'b0; polarity = 1'b0;
        prescale = 8'd0; period = 16'd4; duty_cycle_in = 16'd2; duty_next = 2;
        exp_roll = 1'b0;
        m_run = 1'b0; m_center = 1'b0; m_pwm = 1'b0; m_P = 0; m_ph = 0; m_k = 0;
        @(posedge clk);
        #1;
        step();
        tick_n(2);
        // edge mode, period 4, duty 2
        rst = 1'b0;
        tick_n(22);
        // period change mid-period
        period = 16'd9;
        tick_n(30);
        // center mode, period 3, prescale 1
        enable = 1'b0;
        tick_n(2);
        center_mode = 1'b1; period = 16'd3; prescale = 8'd1; enable = 1'b1;
        tick_n(30);
        // duty boundaries and inverted polarity
        enable = 1'b0;
        tick_n(1);
        center_mode = 1'b0; period = 16'd4; prescale = 8'd0; duty_next = 0; enable = 1'b1;
        tick_n(15);
        duty_next = 5;
        tick_n(15);
        polarity = 1'b1; duty_next = 2;
        tick_n(15);
        // stop at count 3, restart, then reset mid-period
        for (int i = 0; i < 10 && model_count() != 3; i++) tick_n(1);
        enable = 1'b0;
        tick_n(2);
        enable = 1'b1;
        tick_n(7);
        rst = 1'b1;
        tick_n(1);
        rst = 1'b0;
        tick_n(8);
        // randomized segments
        for (int s = 0; s < 25; s++) begin
            int len;
            enable = 1'b0;
            tick_n(1);
            center_mode = 1'($urandom_range(0, 1));
            prescale    = 8'($urandom_range(0, 3));
            period      = 16'($urandom_range(0, 12));
            duty_next   = $urandom_range(0, 14);
            polarity    = 1'($urandom_range(0, 1));
            enable      = 1'b1;
            len = $urandom_range(10, 60);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 19) == 0) period = 16'($urandom_range(0, 12));
                if ($urandom_range(0, 9) == 0) duty_next = $urandom_range(0, 14);
                if ($urandom_range(0, 99) == 0) rst = 1'b1;
                tick_n(1);
                rst = 1'b0;
            end
        end
        enable = 1'b0;
        tick_n(2);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
